// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-rate clock-enable generator.
// Half-periods are counted in 100 MHz sys_clk cycles.
package clk_div_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int HALF_1HZ   = 50000000;
  localparam int HALF_2HZ   = 25000000;
  localparam int HALF_100HZ = 500000;
  localparam int HALF_4HZ   = 12500000;

  // ch0 sits in the low slice: ch0 = 1 Hz, ch1 = 2 Hz, ch2 = 100 Hz, ch3 = 4 Hz blink
  localparam logic [4*CNT_W_DEF-1:0] DIV_INIT_DEF = {
    32'(HALF_4HZ), 32'(HALF_100HZ), 32'(HALF_2HZ), 32'(HALF_1HZ)
  };

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_channel.sv
// One divider lane: counter, shadow/pending half-period, square wave and rise tick.
// A new half-period only lands at a toggle, when H is 0, or on sync_clr, so count is always 0 then.
module div_channel #(
  parameter int               CNT_W  = 32,
  parameter logic [CNT_W-1:0] H_INIT = '0
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] half_q, shadow_q, cnt_q;
  logic             off, wrap, apply;

  assign off   = (half_q == '0);
  assign wrap  = en && !off && (cnt_q == half_q - CNT_W'(1));
  assign apply = pending && (sync_clr || off || wrap);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q   <= H_INIT;
      shadow_q <= '0;
      pending  <= 1'b0;
      cnt_q    <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (sync_clr || off) begin
        cnt_q   <= '0;
        clk_out <= 1'b0;
      end else if (wrap) begin
        cnt_q   <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else if (en) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (apply) begin
        half_q  <= shadow_q;
        pending <= 1'b0;
      end
      // cfg_we only fires while not pending, so it never races an apply
      if (cfg_we) begin
        shadow_q <= cfg_half;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_rate_divider.sv
// Multi-channel clock-enable generator: per-channel 50% square wave plus rise tick,
// half-period reprogrammable per channel through a valid/ready config port.
module multi_rate_divider
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = DIV_INIT_DEF,
  localparam int                     CH_W     = ch_w(NUM_CH)
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0]    pending, cfg_we;
  logic [2**CH_W-1:0]   pend_pad;

  // Unused channel slots read as not-pending, so out-of-range writes see ready and vanish.
  always_comb begin
    pend_pad               = '0;
    pend_pad[NUM_CH-1:0]   = pending;
    cfg_ready              = ~pend_pad[cfg_ch];
    for (int i = 0; i < NUM_CH; i++)
      cfg_we[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    div_channel #(
      .CNT_W  (CNT_W),
      .H_INIT (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_ch (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .en       (en),
      .sync_clr (sync_clr),
      .cfg_we   (cfg_we[i]),
      .cfg_half (cfg_half),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule
